// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: instruction codes, status codes, PC
// select encodings, the "no register" ID and the hazard controller state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [1:0] PC_PRED  = 2'd0;
  localparam logic [1:0] PC_MVALA = 2'd1;
  localparam logic [1:0] PC_WVALM = 2'd2;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RET_DRAIN = 2'd1,
    ST_HALTED    = 2'd2
  } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard controller: load-use stall, mispredict squash, ret
// drain and halt freeze, plus saturating stall/mispredict event counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic             M_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [1:0]       sel_pc,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output state_e           dbg_state
);

  state_e     state_q, state_d;
  logic [1:0] ret_cnt_q, ret_cnt_d;

  logic load_use, mispred, d_ret, m_bad, w_bad;
  logic f_stall_c, d_stall_c, d_bubble_c, e_bubble_c, m_bubble_c, w_stall_c;
  logic set_cc_c, halted_c;
  logic [1:0] sel_pc_c;

  assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                    (E_dstM != REG_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispred  = (E_icode == I_JXX) && !e_Cnd;
  assign d_ret    = (D_icode == I_RET);
  assign m_bad    = (m_stat != S_AOK);
  assign w_bad    = (W_stat != S_AOK);

  always_comb begin
    state_d    = state_q;
    ret_cnt_d  = ret_cnt_q;
    f_stall_c  = 1'b0;
    d_stall_c  = 1'b0;
    d_bubble_c = 1'b0;
    e_bubble_c = 1'b0;
    m_bubble_c = 1'b0;
    w_stall_c  = 1'b0;
    sel_pc_c   = PC_PRED;
    set_cc_c   = 1'b0;
    halted_c   = 1'b0;
    case (state_q)
      ST_HALTED: begin
        halted_c  = 1'b1;
        f_stall_c = 1'b1;
        d_stall_c = 1'b1;
        w_stall_c = 1'b1;
      end
      default: begin
        // Priority: ret drain in progress, then load-use, mispredict, new ret.
        if (state_q == ST_RET_DRAIN) begin
          f_stall_c  = 1'b1;
          d_bubble_c = 1'b1;
          ret_cnt_d  = ret_cnt_q - 2'd1;
          if (ret_cnt_q == 2'd1) state_d = ST_RUN;
        end else if (load_use) begin
          f_stall_c  = 1'b1;
          d_stall_c  = 1'b1;
          e_bubble_c = 1'b1;
        end else if (mispred) begin
          d_bubble_c = 1'b1;
          e_bubble_c = 1'b1;
        end else if (d_ret) begin
          f_stall_c  = 1'b1;
          d_bubble_c = 1'b1;
          state_d    = ST_RET_DRAIN;
          ret_cnt_d  = 2'd3;
        end

        if (W_icode == I_RET)                  sel_pc_c = PC_WVALM;
        else if ((M_icode == I_JXX) && !M_Cnd) sel_pc_c = PC_MVALA;

        if (m_bad || w_bad) m_bubble_c = 1'b1;
        else                set_cc_c   = (E_icode == I_OPQ);

        // A faulted instruction reaching W freezes everything, even mid-drain.
        if (w_bad) begin
          w_stall_c = 1'b1;
          state_d   = ST_HALTED;
          ret_cnt_d = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ret_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign F_stall   = rst_n & f_stall_c;
  assign D_stall   = rst_n & d_stall_c;
  assign D_bubble  = rst_n & d_bubble_c;
  assign E_bubble  = rst_n & e_bubble_c;
  assign M_bubble  = rst_n & m_bubble_c;
  assign W_stall   = rst_n & w_stall_c;
  assign sel_pc    = rst_n ? sel_pc_c : PC_PRED;
  assign set_cc    = rst_n & set_cc_c;
  assign halted    = rst_n & halted_c;
  assign dbg_state = state_q;

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (f_stall_c && (state_q != ST_HALTED)),
    .cnt_o (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (mispred && (state_q == ST_RUN)),
    .cnt_o (mispred_cnt)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; one clock; asynchronous, active-low.
REQ-004 SHALL have ports D_icode, E_icode, M_icode, W_icode  in  4 each  stage instruction codes.
REQ-005 SHALL have ports d_srcA, d_srcB, E_dstM  in  4 each  register IDs; 4'hF = none.
REQ-006 SHALL have ports e_Cnd, M_Cnd  in  1 each  branch condition in E and M.
REQ-007 SHALL have ports m_stat, W_stat  in  3 each  status codes (AOK=1, HLT=2, ADR=3, INS=4).
REQ-008 SHALL have ports F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls.
REQ-009 SHALL have port sel_pc  out  2  next-PC source: 0=FpredPC, 1=MvalA, 2=WvalM.
REQ-010 SHALL have port set_cc  out  1  condition-code write enable.
REQ-011 SHALL have port halted  out  1  pipeline frozen.
REQ-012 SHALL have ports stall_cnt, mispred_cnt  out  CNT_W each  saturating event counters.

Function
REQ-013 SHALL implement FSM states RUN, RET_DRAIN, HALTED.
REQ-014 All control outputs SHALL be combinational from the current inputs and registered state, so they take effect at the same clock edge.
REQ-015 load_use SHALL be asserted when E_icode is MRMOVQ or POPQ, E_dstM != 4'hF, and E_dstM equals d_srcA or d_srcB.
REQ-016 mispred SHALL be asserted when E_icode==JXX and e_Cnd==0.
REQ-017 In RUN with load_use: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-018 In RUN with mispred and no load_use: D_bubble=1, E_bubble=1.
REQ-019 In RUN with D_icode==RET, no load_use, no mispred: F_stall=1, D_bubble=1, next state RET_DRAIN, ret_cnt loaded with 3.
REQ-020 In RET_DRAIN: F_stall=1, D_bubble=1, ret_cnt decrements each cycle; when ret_cnt==1, next state is RUN.
REQ-021 sel_pc SHALL be 2 when W_icode==RET; else 1 when M_icode==JXX and M_Cnd==0; else 0.
REQ-022 When m_stat!=AOK or W_stat!=AOK: M_bubble=1 and set_cc=0.
REQ-023 Otherwise set_cc SHALL be 1 exactly when E_icode==OPQ.
REQ-024 When W_stat!=AOK in any state: W_stall=1 and next state is HALTED; this overrides RET_DRAIN and all other transitions.
REQ-025 In HALTED: halted=1, F_stall=1, D_stall=1, W_stall=1, all bubbles 0, set_cc=0, sel_pc=0; exit only by reset.
REQ-026 stall_cnt SHALL increment on each cycle with F_stall=1 outside HALTED.
REQ-027 mispred_cnt SHALL increment on each cycle with mispred=1 in RUN.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.
REQ-029 Simultaneous load_use and D_icode==RET: load_use wins; RET_DRAIN entry is deferred until D is released.
REQ-030 Simultaneous mispred and D_icode==RET: mispred wins; the ret is bubbled and RET_DRAIN is not entered.

Reset
REQ-031 While rst_n==0, state SHALL be RUN, ret_cnt=0 and both counters=0.
REQ-032 While rst_n==0, halted=0, sel_pc=0, all stall/bubble outputs=0 and set_cc=0.
REQ-033 Reset asserted mid-RET_DRAIN or in HALTED SHALL return the block to RUN asynchronously; no residual stall may follow deassertion.

Structure
REQ-034 Shared package y86_pkg SHALL hold the icode constants, the status codes, the sel_pc encodings, the REG_NONE (4'hF) constant and the FSM state type.
REQ-035 One sub-module, sat_cnt (parameterised width, enable, async active-low clear), SHALL be instantiated twice, once per counter.
REQ-036 The FSM and hazard decode SHALL remain in pipe_ctrl.

Verification
REQ-037 Load-use: E_icode=MRMOVQ, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0, stall_cnt +1.
REQ-038 Ret drain: D_icode=RET, then RET advancing through E, M, W -> F_stall=1 for 4 consecutive cycles, sel_pc=2 in the W cycle, RUN afterwards.
REQ-039 Mispredict: E_icode=JXX, e_Cnd=0 -> D_bubble=E_bubble=1 and mispred_cnt +1; next cycle M_icode=JXX, M_Cnd=0 -> sel_pc=1.
REQ-040 Halt: m_stat=HLT -> M_bubble=1, set_cc=0; next cycle W_stat=HLT -> HALTED with halted=1 held for 10+ cycles.
REQ-041 Precedence: D_icode=RET together with a load_use -> no RET_DRAIN entry that cycle; D_icode=RET together with a mispred -> RET bubbled, stays RUN.
REQ-042 Saturation/reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15; assert rst_n=0 mid-RET_DRAIN -> all outputs 0 immediately.
